// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV32M multiply/divide unit feeding the register-file write port
// Ports: clk/rst (sync active-high); in_valid/in_ready/in_op/in_rs1/in_rs2/in_rd request side;
// out_valid/out_ready/out_waddr/out_wdata/out_wen result side; busy while not IDLE.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle multiplier for MUL/MULH/MULHSU/MULHU.
module muldiv_iter #(
  parameter int DATA_WIDTH  = 32,
  parameter int REG_NUM_BIT = 5,
  parameter int CNT_BIT     = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_op,
  input  logic [DATA_WIDTH-1:0]  in_rs1,
  input  logic [DATA_WIDTH-1:0]  in_rs2,
  input  logic [REG_NUM_BIT-1:0] in_rd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [REG_NUM_BIT-1:0] out_waddr,
  output logic [DATA_WIDTH-1:0]  out_wdata,
  output logic                   out_wen,
  output logic                   busy
);
  localparam int W = DATA_WIDTH;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t                 state_q;
  logic [CNT_BIT-1:0]     cnt_q;
  logic [2:0]             op_q;
  logic [REG_NUM_BIT-1:0] rd_q;
  logic [W-1:0]           hi_q, lo_q, b_q, res_q;
  logic                   neg_q, rem_neg_q;
  logic                   a_sgn, b_sgn, a_neg, b_neg, div_zero, ovf, quick;
  logic [W-1:0]           a_mag, b_mag, spec_res, quick_res, hi_d, lo_d, fin;
  logic [W:0]             mul_sum, div_sh, div_diff;
  logic [2*W-1:0]         prod;
`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*W-1:0]  fa, fb, fp;
`endif
  always_comb begin
    a_sgn    = (in_op != 3'd3) & ~(in_op[2] & in_op[0]);
    b_sgn    = a_sgn & (in_op != 3'd2);
    a_neg    = a_sgn & in_rs1[W-1];
    b_neg    = b_sgn & in_rs2[W-1];
    a_mag    = a_neg ? -in_rs1 : in_rs1;
    b_mag    = b_neg ? -in_rs2 : in_rs2;
    div_zero = in_op[2] & (in_rs2 == '0);
    ovf      = in_op[2] & ~in_op[0] & (in_rs1 == {1'b1, {(W-1){1'b0}}}) & (&in_rs2);
    spec_res = div_zero ? (in_op[1] ? in_rs1 : '1) : (in_op[1] ? '0 : {1'b1, {(W-1){1'b0}}});
`ifdef MULDIV_FAST_MUL_EN
    // sign-extended operands multiplied modulo 2^(2W) give the exact 2W-bit product
    fa        = {{W{a_neg}}, in_rs1};
    fb        = {{W{b_neg}}, in_rs2};
    fp        = fa * fb;
    quick     = div_zero | ovf | ~in_op[2];
    quick_res = in_op[2] ? spec_res : (in_op == 3'd0 ? fp[W-1:0] : fp[2*W-1:W]);
`else
    quick     = div_zero | ovf;
    quick_res = spec_res;
`endif
    // hi:lo holds partial product (mul) or remainder:quotient (div)
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_sh   = {hi_q, lo_q[W-1]};
    div_diff = div_sh - {1'b0, b_q};
    hi_d     = op_q[2] ? (div_diff[W] ? div_sh[W-1:0] : div_diff[W-1:0]) : mul_sum[W:1];
    lo_d     = op_q[2] ? {lo_q[W-2:0], ~div_diff[W]} : {mul_sum[0], lo_q[W-1:1]};
    prod     = neg_q ? -{hi_d, lo_d} : {hi_d, lo_d};
    fin      = op_q[2] ? (op_q[1] ? (rem_neg_q ? -hi_d : hi_d) : (neg_q ? -lo_d : lo_d))
                       : (op_q == 3'd0 ? prod[W-1:0] : prod[2*W-1:W]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      res_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          op_q      <= in_op;
          rd_q      <= in_rd;
          hi_q      <= '0;
          lo_q      <= a_mag;
          b_q       <= b_mag;
          neg_q     <= a_neg ^ b_neg;
          rem_neg_q <= a_neg;
          cnt_q     <= '0;
          res_q     <= quick_res;
          state_q   <= quick ? DONE : BUSY;
        end
        BUSY: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_BIT'(W-1)) begin
            res_q   <= fin;
            cnt_q   <= '0;
            state_q <= DONE;
          end
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready  = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign out_valid = state_q == DONE;
  assign out_waddr = rd_q;
  assign out_wdata = res_q;
  assign out_wen   = out_valid & (rd_q != '0);
endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: directed self-checking bench for muldiv_iter
module tb_muldiv_iter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [31:0] in_rs1 = '0, in_rs2 = '0;
  logic [4:0]  in_rd = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_waddr;
  logic [31:0] out_wdata;
  logic        out_wen;
  logic        busy;
  int total = 0;
  int bad = 0;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = 32;
`endif
  always #5 clk = ~clk;
  muldiv_iter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .out_valid(out_valid),
    .out_ready(out_ready), .out_waddr(out_waddr), .out_wdata(out_wdata),
    .out_wen(out_wen), .busy(busy)
  );
  // lat = edges after the accept edge until out_valid, -1 if it never came
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int lat);
    int w = 0;
    while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
    in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b; in_rd = rd;
    @(posedge clk); #1;
    in_valid = 1'b0; in_op = ~op; in_rs1 = ~a; in_rs2 = ~b; in_rd = ~rd;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!out_valid) lat = -1;
  endtask
  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid got=%b exp=0", out_valid); end
    total++; if (out_wen !== 1'b0) begin bad++; $display("FAIL reset out_wen got=%b exp=0", out_wen); end
    total++; if (out_waddr !== 5'd0) begin bad++; $display("FAIL reset out_waddr got=%0d exp=0", out_waddr); end
    total++; if (out_wdata !== 32'd0) begin bad++; $display("FAIL reset out_wdata got=%h exp=0", out_wdata); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b exp=0", busy); end
    rst = 1'b0;
  endtask
  task automatic test_reset_busy();
    logic seen = 1'b0;
`ifdef MULDIV_FAST_MUL_EN
    in_op = 3'd5;
`else
    in_op = 3'd0;
`endif
    in_valid = 1'b1; in_rs1 = 32'd7; in_rs2 = 32'hFFFFFFFD; in_rd = 5'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstbusy busy got=%b exp=1", busy); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rstbusy in_ready got=%b exp=0", in_ready); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstbusy post in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstbusy post out_valid got=%b exp=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstbusy post busy got=%b exp=0", busy); end
    repeat (40) begin @(posedge clk); #1; seen |= out_valid; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstbusy stale result got=%b exp=0", seen); end
  endtask
  task automatic test_mul();
    logic [2:0]  ov[4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [31:0] av[4] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] bv[4] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ev[4] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE};
    int lat;
    for (int i = 0; i < 4; i++) begin
      issue(ov[i], av[i], bv[i], 5'(i + 1), lat);
      total++; if (lat !== MUL_LAT) begin bad++; $display("FAIL mul[%0d] latency got=%0d exp=%0d", i, lat, MUL_LAT); end
      total++; if (out_wdata !== ev[i]) begin bad++; $display("FAIL mul[%0d] wdata got=%h exp=%h", i, out_wdata, ev[i]); end
      total++; if (out_waddr !== 5'(i + 1) || out_wen !== 1'b1) begin bad++; $display("FAIL mul[%0d] waddr/wen got=%0d/%b exp=%0d/1", i, out_waddr, out_wen, i + 1); end
      consume();
    end
  endtask
  task automatic test_div();
    logic [2:0]  ov[4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] av[4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd100};
    logic [31:0] bv[4] = '{32'd2, 32'd2, 32'd2, 32'd7};
    logic [31:0] ev[4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'd2};
    int lat;
    for (int i = 0; i < 4; i++) begin
      issue(ov[i], av[i], bv[i], 5'd9, lat);
      total++; if (lat !== 32) begin bad++; $display("FAIL div[%0d] latency got=%0d exp=32", i, lat); end
      total++; if (out_wdata !== ev[i]) begin bad++; $display("FAIL div[%0d] wdata got=%h exp=%h", i, out_wdata, ev[i]); end
      consume();
    end
  endtask
  task automatic test_special();
    logic [2:0]  ov[4] = '{3'd4, 3'd7, 3'd4, 3'd6};
    logic [31:0] av[4] = '{32'd123, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] bv[4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ev[4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
    int lat;
    for (int i = 0; i < 4; i++) begin
      issue(ov[i], av[i], bv[i], 5'd4, lat);
      total++; if (lat !== 0) begin bad++; $display("FAIL special[%0d] latency got=%0d exp=0", i, lat); end
      total++; if (out_wdata !== ev[i]) begin bad++; $display("FAIL special[%0d] wdata got=%h exp=%h", i, out_wdata, ev[i]); end
      consume();
    end
  endtask
  task automatic test_backpressure();
    int lat;
    issue(3'd4, 32'd9, 32'd0, 5'd7, lat);
    total++; if (lat !== 0) begin bad++; $display("FAIL bp first latency got=%0d exp=0", lat); end
    in_valid = 1'b1; in_op = 3'd5; in_rs1 = 32'd9; in_rs2 = 32'd3; in_rd = 5'd15;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL bp[%0d] valid/ready got=%b/%b exp=1/0", i, out_valid, in_ready); end
      total++; if (out_waddr !== 5'd7 || out_wdata !== 32'hFFFFFFFF) begin bad++; $display("FAIL bp[%0d] hold got=%0d/%h exp=7/ffffffff", i, out_waddr, out_wdata); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL bp release valid/ready got=%b/%b exp=0/1", out_valid, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp next accept busy got=%b exp=1", busy); end
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    total++; if (lat !== 32) begin bad++; $display("FAIL bp next latency got=%0d exp=32", lat); end
    total++; if (out_wdata !== 32'd3 || out_waddr !== 5'd15 || out_wen !== 1'b1) begin bad++; $display("FAIL bp next result got=%h/%0d/%b exp=3/15/1", out_wdata, out_waddr, out_wen); end
    consume();
  endtask
  task automatic test_rd0();
    int lat;
    issue(3'd5, 32'd9, 32'd3, 5'd0, lat);
    total++; if (lat !== 32) begin bad++; $display("FAIL rd0 latency got=%0d exp=32", lat); end
    total++; if (out_valid !== 1'b1 || out_wen !== 1'b0) begin bad++; $display("FAIL rd0 valid/wen got=%b/%b exp=1/0", out_valid, out_wen); end
    total++; if (out_wdata !== 32'd3) begin bad++; $display("FAIL rd0 wdata got=%h exp=3", out_wdata); end
    consume();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL rd0 handshake valid/ready got=%b/%b exp=0/1", out_valid, in_ready); end
  endtask
  initial begin
    test_reset();
    test_reset_busy();
    test_mul();
    test_div();
    test_special();
    test_backpressure();
    test_rd0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
